// File: rtl/cordic_vector_pipe.sv
// Fully pipelined vectoring-mode CORDIC: (x, y) -> (magnitude, atan2 angle), Q4.20 throughout.
// One quadrant pre-rotation stage, STAGE_CNT micro-rotations, one gain-compensation stage.
module cordic_vector_pipe #(
    parameter int unsigned          NUM_WIDTH       = 24,
    parameter int unsigned          STAGE_CNT       = 20,
    parameter logic [NUM_WIDTH-1:0] CORDIC_GAIN_INV = 24'h09B74E,
    parameter logic [NUM_WIDTH-1:0] ATAN [32]       = '{
        0:  24'h0C90FE, 1:  24'h076B1A, 2:  24'h03EB6F, 3:  24'h01FD5C,
        4:  24'h00FFAB, 5:  24'h007FF5, 6:  24'h003FFF, 7:  24'h002000,
        8:  24'h001000, 9:  24'h000800, 10: 24'h000400, 11: 24'h000200,
        12: 24'h000100, 13: 24'h000080, 14: 24'h000040, 15: 24'h000020,
        16: 24'h000010, 17: 24'h000008, 18: 24'h000004, 19: 24'h000002,
        20: 24'h000001, 21: 24'h000001, default: '0
    }
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [NUM_WIDTH-1:0] in_x,
    input  logic [NUM_WIDTH-1:0] in_y,
    output logic                 out_valid,
    output logic [NUM_WIDTH-1:0] out_mag,
    output logic [NUM_WIDTH-1:0] out_angle
);

    localparam int unsigned          DW      = NUM_WIDTH + 2;
    localparam int unsigned          PW      = DW + NUM_WIDTH + 1;
    localparam logic [NUM_WIDTH-1:0] HALF_PI = 24'h1921FB;

    // Index k holds the result of stage P (k=0) or micro-rotation k-1 (k>0).
    logic signed [DW-1:0]    r_x   [STAGE_CNT+1];
    logic signed [DW-1:0]    r_y   [STAGE_CNT];
    logic [NUM_WIDTH-1:0]    r_z   [STAGE_CNT+1];
    logic signed [DW-1:0]    w_x_d [STAGE_CNT+1];
    logic signed [DW-1:0]    w_y_d [STAGE_CNT];
    logic [NUM_WIDTH-1:0]    w_z_d [STAGE_CNT+1];
    logic [STAGE_CNT+1:0]    r_vld;
    logic [STAGE_CNT:0]      r_zero;
    logic [NUM_WIDTH-1:0]    r_mag;
    logic [NUM_WIDTH-1:0]    r_angle;
    logic signed [DW-1:0]    w_in_x;
    logic signed [DW-1:0]    w_in_y;
    logic                    w_in_zero;
    logic signed [PW-1:0]    w_prod;
    logic signed [PW-1:0]    w_prod_sh;
    logic [NUM_WIDTH-1:0]    w_mag;

    assign w_in_x    = {{2{in_x[NUM_WIDTH-1]}}, in_x};
    assign w_in_y    = {{2{in_y[NUM_WIDTH-1]}}, in_y};
    assign w_in_zero = (in_x == '0) && (in_y == '0);

    always_comb begin
        w_x_d[0] = w_in_x;
        w_y_d[0] = w_in_y;
        w_z_d[0] = '0;
        if (w_in_x[DW-1] && !w_in_y[DW-1]) begin
            w_x_d[0] = w_in_y;
            w_y_d[0] = -w_in_x;
            w_z_d[0] = HALF_PI;
        end else if (w_in_x[DW-1]) begin
            w_x_d[0] = -w_in_y;
            w_y_d[0] = w_in_x;
            w_z_d[0] = -HALF_PI;
        end
        for (int i = 0; i < int'(STAGE_CNT); i++) begin
            if (r_y[i][DW-1]) begin
                w_x_d[i+1] = r_x[i] - (r_y[i] >>> i);
                w_z_d[i+1] = r_z[i] - ATAN[i];
            end else begin
                w_x_d[i+1] = r_x[i] + (r_y[i] >>> i);
                w_z_d[i+1] = r_z[i] + ATAN[i];
            end
            // The last stage's y residual is never consumed, so it is not stored.
            if (i < int'(STAGE_CNT) - 1) begin
                if (r_y[i][DW-1]) begin
                    w_y_d[i+1] = r_y[i] + (r_x[i] >>> i);
                end else begin
                    w_y_d[i+1] = r_y[i] - (r_x[i] >>> i);
                end
            end
        end
    end

    assign w_prod    = r_x[STAGE_CNT] * $signed({1'b0, CORDIC_GAIN_INV});
    assign w_prod_sh = w_prod >>> 20;

    always_comb begin
        if (w_prod_sh[PW-1]) begin
            w_mag = '0;
        end else if (|w_prod_sh[PW-2:NUM_WIDTH-1]) begin
            w_mag = {1'b0, {(NUM_WIDTH-1){1'b1}}};
        end else begin
            w_mag = w_prod_sh[NUM_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x     <= '{default: '0};
            r_y     <= '{default: '0};
            r_z     <= '{default: '0};
            r_vld   <= '0;
            r_zero  <= '0;
            r_mag   <= '0;
            r_angle <= '0;
        end else begin
            r_x    <= w_x_d;
            r_y    <= w_y_d;
            r_z    <= w_z_d;
            r_vld  <= {r_vld[STAGE_CNT:0], in_valid};
            r_zero <= {r_zero[STAGE_CNT-1:0], w_in_zero};
            if (r_vld[STAGE_CNT]) begin
                r_mag <= w_mag;
                // A null vector never drives y negative, so z would drift; its angle is 0.
                r_angle <= r_zero[STAGE_CNT] ? '0 : r_z[STAGE_CNT];
            end
        end
    end

    assign out_valid = r_vld[STAGE_CNT+1];
    assign out_mag   = r_mag;
    assign out_angle = r_angle;

endmodule

// File: tb/tb_cordic_vector_pipe.sv
// Self-checking bench for cordic_vector_pipe: directed table, back-to-back, reset flush and
// random vectors compared against real-valued atan2/hypot with a 64 LSB tolerance.
module tb_cordic_vector_pipe;

    localparam int  W     = 24;
    localparam int  LAT   = 22;
    localparam int  NVEC  = 10;
    localparam int  NRAND = 10000;
    localparam real SCALE = 1048576.0;
    localparam real TOL   = 64.0;
    localparam real PI    = 3.14159265358979;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_x;
    logic [W-1:0] in_y;
    logic         out_valid;
    logic [W-1:0] out_mag;
    logic [W-1:0] out_angle;

    cordic_vector_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_x      (in_x),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_mag   (out_mag),
        .out_angle (out_angle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int  cyc;
        real mag;
        real ang;
        bit  wrap;
        int  id;
    } exp_t;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] mag;
        logic [W-1:0] ang;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[NVEC];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    int   n_acc    = 0;
    exp_t mon_e;
    real  mon_act;
    real  mon_req;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic real to_r(input logic [W-1:0] v);
        return $itor($signed(v)) / SCALE;
    endfunction

    task automatic chk_eq(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic chk_near(input string nm, input int id, input real act, input real req);
        n_checks++;
        if (act - req > TOL || req - act > TOL) begin
            n_fail++;
            $display("FAIL %s id=%0d: got %0.1f LSB, expected %0.1f LSB +/-64", nm, id, act, req);
        end
    endtask

    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input real m,
                         input real a, input bit wrap, input int id);
        exp_t e;
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        e.cyc    = cyc;
        e.mag    = m;
        e.ang    = a;
        e.wrap   = wrap;
        e.id     = id;
        sb.push_back(e);
        n_acc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk_eq("drain_pending", sb.size(), 0);
    endtask

    // Scoreboard: each out_valid pulse must match the oldest outstanding sample.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            n_out++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_out_valid: got 1 at cycle %0d, expected 0", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk_eq("latency", cyc - mon_e.cyc, LAT);
                chk_near("mag", mon_e.id, $itor($signed(out_mag)), mon_e.mag * SCALE);
                mon_act = $itor($signed(out_angle));
                mon_req = mon_e.ang * SCALE;
                if (mon_e.wrap) begin
                    if (mon_req - mon_act > PI * SCALE) mon_req = mon_req - 2.0 * PI * SCALE;
                    else if (mon_act - mon_req > PI * SCALE) mon_req = mon_req + 2.0 * PI * SCALE;
                end
                chk_near("angle", mon_e.id, mon_act, mon_req);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int rx;
        int ry;
        int sent;
        real rr;

        tbl[0] = '{x: 24'h100000, y: 24'h000000, mag: 24'h100000, ang: 24'h000000};
        tbl[1] = '{x: 24'h100000, y: 24'h100000, mag: 24'h16A09E, ang: 24'h0C90FE};
        tbl[2] = '{x: 24'h000000, y: 24'h100000, mag: 24'h100000, ang: 24'h1921FB};
        tbl[3] = '{x: 24'hF00000, y: 24'h000000, mag: 24'h100000, ang: 24'h3243F7};
        tbl[4] = '{x: 24'h000000, y: 24'hF00000, mag: 24'h100000, ang: 24'hE6DE05};
        tbl[5] = '{x: 24'hF00000, y: 24'hF00000, mag: 24'h16A09E, ang: 24'hDA4D07};
        tbl[6] = '{x: 24'hF00000, y: 24'h100000, mag: 24'h16A09E, ang: 24'h25B2F9};
        tbl[7] = '{x: 24'h080000, y: 24'hF80000, mag: 24'h0B504F, ang: 24'hF36F02};
        tbl[8] = '{x: 24'h000000, y: 24'h000000, mag: 24'h000000, ang: 24'h000000};
        tbl[9] = '{x: 24'h180000, y: 24'h000000, mag: 24'h180000, ang: 24'h000000};

        // Reset with in_valid held high: must be ignored.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_x     = 24'h100000;
        in_y     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_out_valid", int'(out_valid), 0);
        chk_eq("rst_out_mag", int'(out_mag), 0);
        chk_eq("rst_out_angle", int'(out_angle), 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk_eq("idle_out_valid", int'(out_valid), 0);

        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].x, tbl[i].y, to_r(tbl[i].mag), to_r(tbl[i].ang), 1'b0, i);
            in_valid = 1'b0;
            drain(100);
        end

        drive(24'h100000, 24'h000000, 1.0, 0.0, 1'b0, 100);
        drive(24'h000000, 24'h100000, 1.0, PI / 2.0, 1'b0, 101);
        drive(24'h100000, 24'h100000, $sqrt(2.0), PI / 4.0, 1'b0, 102);
        in_valid = 1'b0;
        drain(100);

        // Reset while a sample is in flight: it must vanish.
        c0 = cyc;
        drive(24'h100000, 24'h000000, 1.0, 0.0, 1'b0, 200);
        in_valid = 1'b0;
        while (cyc < c0 + 10) @(posedge clk);
        #1;
        rst   = 1'b1;
        n_acc = n_acc - sb.size();
        sb.delete();
        in_valid = 1'b1;
        #1;
        chk_eq("async_rst_out_valid", int'(out_valid), 0);
        chk_eq("async_rst_out_mag", int'(out_mag), 0);
        chk_eq("async_rst_out_angle", int'(out_angle), 0);
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        while (cyc <= c0 + 40) begin
            @(negedge clk);
            chk_eq("flush_out_valid", int'(out_valid), 0);
            @(posedge clk);
            #1;
        end
        drive(24'h000000, 24'h100000, 1.0, PI / 2.0, 1'b0, 201);
        in_valid = 1'b0;
        drain(100);

        sent = 0;
        while (sent < NRAND) begin
            if ($urandom_range(3, 0) != 0) begin
                do begin
                    rx = int'($urandom_range(3800000, 0)) - 1900000;
                    ry = int'($urandom_range(3800000, 0)) - 1900000;
                    rr = $sqrt(real'(rx) * real'(rx) + real'(ry) * real'(ry));
                end while (rr < 524288.0);
                drive(rx[W-1:0], ry[W-1:0], rr / SCALE, $atan2(real'(ry), real'(rx)), 1'b1,
                      1000 + sent);
                sent++;
            end else begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        drain(200);
        chk_eq("out_count", n_out, n_acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
